led_blink_ctrl: RTL and testbench

- Parametrised N-channel LED driver. Next generation of the fixed-rate, clock-divider LED blink path.
- Each channel has a registered mode (OFF / ON / BLINK / ONESHOT) and a phase-accumulator tuning word. Channels are loaded through a masked load strobe.
- Sits between the switch/config logic and the board LED pins. Clocked by the ~48 MHz on-chip oscillator.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_blink_ctrl_if.sv | 23 ++
 rtl/led_blink_chan.sv | 70 +++++++
 rtl/led_blink_ctrl.sv | 34 +++
 tb/tb_led_blink_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the multi-channel LED blink controller.
// Also used by the config logic and benches when computing tuning words.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } led_mode_t;

  localparam int CLK_HZ = 48_000_000;

  // LED level a channel shows on the edge it is loaded into a mode.
  function automatic logic ledStartLevel(led_mode_t mode);
    return (mode == MODE_ON) || (mode == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Channel load bus and LED outputs between the config logic and the LED driver.
interface led_blink_ctrl_if #(
  parameter int N_CH  = 3,
  parameter int ACC_W = 24
);

  logic [N_CH-1:0]       load;
  logic [2*N_CH-1:0]     mode_in;
  logic [ACC_W*N_CH-1:0] tune_in;
  logic [N_CH-1:0]       led;
  logic [N_CH-1:0]       done;

  modport master (
    output load, mode_in, tune_in,
    input  led, done
  );

  modport slave (
    input  load, mode_in, tune_in,
    output led, done
  );

endinterface

// File: rtl/led_blink_chan.sv
// One LED channel: mode/tune registers, phase accumulator, registered led and
// sticky oneshot-done flag.
module led_blink_chan
  import led_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  led_mode_t        mode_i,
  input  logic [ACC_W-1:0] tune_i,
  output logic             led_o,
  output logic             done_o
);

  led_mode_t        mode_q;
  logic [ACC_W-1:0] tune_q;
  logic [ACC_W-1:0] acc_q;
  logic             led_q;
  logic             done_q;
  logic [ACC_W:0]   sum_d;

  always_comb begin
    sum_d = {1'b0, acc_q} + {1'b0, tune_q};
  end

  // A load wins over any same-edge carry, so an aborted shot never reports done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_OFF;
      tune_q <= '0;
      acc_q  <= '0;
      led_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (load_i) begin
      mode_q <= mode_i;
      tune_q <= tune_i;
      acc_q  <= '0;
      led_q  <= ledStartLevel(mode_i);
      done_q <= 1'b0;
    end else begin
      case (mode_q)
        MODE_OFF: led_q <= 1'b0;
        MODE_ON:  led_q <= 1'b1;
        MODE_BLINK: begin
          acc_q <= sum_d[ACC_W-1:0];
          led_q <= sum_d[ACC_W-1];
        end
        MODE_ONESHOT: begin
          if (done_q) begin
            led_q <= 1'b0;
          end else if (sum_d[ACC_W]) begin
            acc_q  <= '0;
            led_q  <= 1'b0;
            done_q <= 1'b1;
          end else begin
            acc_q <= sum_d[ACC_W-1:0];
            led_q <= 1'b1;
          end
        end
        default: led_q <= 1'b0;
      endcase
    end
  end

  assign led_o  = led_q;
  assign done_o = done_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// N-channel LED driver top: slices the packed load/mode/tune buses onto
// independent led_blink_chan instances.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  led_blink_ctrl_if.slave  bus
);

  logic [N_CH-1:0] ledVec;
  logic [N_CH-1:0] doneVec;

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    led_blink_chan #(
      .ACC_W (ACC_W)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .load_i (bus.load[k]),
      .mode_i (led_mode_t'(bus.mode_in[2*k +: 2])),
      .tune_i (bus.tune_in[ACC_W*k +: ACC_W]),
      .led_o  (ledVec[k]),
      .done_o (doneVec[k])
    );
  end

  assign bus.led  = ledVec;
  assign bus.done = doneVec;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl with N_CH=3, ACC_W=8: reset, blink,
// oneshot, reload priority, mixed modes, async reset and accumulator wrap.
module tb_led_blink_ctrl;
  import led_pkg::*;

  localparam int N_CH  = 3;
  localparam int ACC_W = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  led_blink_ctrl_if #(.N_CH(N_CH), .ACC_W(ACC_W)) bus ();

  led_blink_ctrl #(
    .N_CH  (N_CH),
    .ACC_W (ACC_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] loadV, input logic [5:0] modeV,
                               input logic [23:0] tuneV);
    bus.load    = loadV;
    bus.mode_in = modeV;
    bus.tune_in = tuneV;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] accModel;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    applyStimulus(3'b000, 6'd0, 24'd0);

    // Reset held with random activity on the inputs
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'($urandom), 6'($urandom), 24'($urandom));
      tick();
      checkOutput("rst_led", 32'(bus.led), 32'd0);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
    end
    applyStimulus(3'b000, 6'd0, 24'd0);
    reset = 1'b1;
    tick();
    checkOutput("post_rst_led", 32'(bus.led), 32'd0);

    // BLINK ch0, tune 64: 0,0,1,1 from the load edge
    applyStimulus(3'b001, 6'b00_00_10, {8'd0, 8'd0, 8'd64});
    tick();
    bus.load = 3'b000;
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("blink_led0_%0d", i), 32'(bus.led[0]), 32'((i % 4) >= 2));
      checkOutput("blink_led21", 32'(bus.led[2:1]), 32'd0);
      tick();
    end

    // ONESHOT ch1, tune 32: 8 cycles high then done
    applyStimulus(3'b010, 6'b00_11_00, {8'd0, 8'd32, 8'd0});
    tick();
    bus.load = 3'b000;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("shot_led1_%0d", i), 32'(bus.led[1]), 32'd1);
      checkOutput($sformatf("shot_done1_%0d", i), 32'(bus.done[1]), 32'd0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("shot_idle_led1_%0d", i), 32'(bus.led[1]), 32'd0);
      checkOutput($sformatf("shot_idle_done1_%0d", i), 32'(bus.done[1]), 32'd1);
      tick();
    end

    // Reload on the exact carry edge
    applyStimulus(3'b010, 6'b00_11_00, {8'd0, 8'd32, 8'd0});
    tick();
    checkOutput("reload_clears_done", 32'(bus.done[1]), 32'd0);
    bus.load = 3'b000;
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("pre_led1_%0d", i), 32'(bus.led[1]), 32'd1);
      tick();
    end
    applyStimulus(3'b010, 6'b00_11_00, {8'd0, 8'd32, 8'd0});
    tick();
    checkOutput("reload_edge_led1", 32'(bus.led[1]), 32'd1);
    checkOutput("reload_edge_done1", 32'(bus.done[1]), 32'd0);
    bus.load = 3'b000;
    for (int i = 1; i < 8; i++) begin
      tick();
      checkOutput($sformatf("fresh_led1_%0d", i), 32'(bus.led[1]), 32'd1);
      checkOutput($sformatf("fresh_done1_%0d", i), 32'(bus.done[1]), 32'd0);
    end
    tick();
    checkOutput("fresh_end_led1", 32'(bus.led[1]), 32'd0);
    checkOutput("fresh_end_done1", 32'(bus.done[1]), 32'd1);

    // Mixed simultaneous load: ON / BLINK 128 / OFF
    applyStimulus(3'b111, 6'b00_10_01, {8'd0, 8'd128, 8'd0});
    tick();
    bus.load = 3'b000;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("mixed_led_%0d", i), 32'(bus.led), 32'({1'b0, (i % 2) == 1, 1'b1}));
      checkOutput($sformatf("mixed_done_%0d", i), 32'(bus.done), 32'd0);
      tick();
    end

    // BLINK with tune 0 freezes
    applyStimulus(3'b010, 6'b00_10_00, {8'd0, 8'd0, 8'd0});
    tick();
    bus.load = 3'b000;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("freeze_led_%0d", i), 32'(bus.led), 32'b001);
      tick();
    end

    // Asynchronous reset mid-cycle
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_led", 32'(bus.led), 32'd0);
    checkOutput("async_rst_done", 32'(bus.done), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("after_async_led", 32'(bus.led), 32'd0);

    // Wrap: BLINK ch2 tune 255 against a reference accumulator
    applyStimulus(3'b100, 6'b10_00_00, {8'd255, 8'd0, 8'd0});
    tick();
    bus.load = 3'b000;
    accModel = 8'd0;
    for (int i = 0; i < 600; i++) begin
      checkOutput($sformatf("wrap_led2_%0d", i), 32'(bus.led[2]), 32'(accModel[7]));
      tick();
      accModel = accModel + 8'd255;
    end
    checkOutput("wrap_led10", 32'(bus.led[1:0]), 32'd0);
    checkOutput("wrap_done", 32'(bus.done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
